// File: rtl/byte_stream_packer_pkg.sv
// Shared types and helpers for the byte stream packer.
//   byte_t    : one stream byte
//   lane_idx  : output lane written by the byte at fill position cnt
package stream_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned DEFAULT_WORD_BYTES = 4;

  // swap=0: first byte lands in the most significant lane; swap=1: in lane 0.
  // The mapping is its own inverse, so it also gives the fill position of a lane.
  function automatic int unsigned lane_idx(input int unsigned cnt,
                                           input int unsigned wb,
                                           input bit          swap);
    return swap ? cnt : (wb - 1 - cnt);
  endfunction

endpackage

// File: rtl/byte_stream_packer_fifo2.sv
// Two-entry FIFO for finished words.
//   clk, rst   : clock, asynchronous active-high reset
//   push, pop  : write din / drop the head entry (both allowed in one cycle)
//   full, empty: occupancy flags
//   din, dout  : payload in, head payload out (held while empty)
module packer_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         do_push, do_pop;

  assign full  = (occ_q == 2'd2);
  assign empty = (occ_q == 2'd0);
  // The head is a dedicated register so the output keeps its last value once drained.
  assign dout  = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (occ_q == 2'd0) begin
      if (do_push) head_d = din;
    end else if (occ_q == 2'd1) begin
      if (do_push && do_pop) head_d = din;
      else if (do_push)      tail_d = din;
    end else begin
      if (do_pop) begin
        head_d = tail_q;
        if (do_push) tail_d = din;
      end
    end
    occ_d = occ_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/byte_stream_packer.sv
// Packs a valid/ready byte stream into WORD_BYTES-wide words.
//   in_valid/in_ready/in_data/in_last : byte input handshake, in_last ends a packet
//   out_valid/out_ready               : word output handshake from a 2-entry buffer
//   out_data/out_bytes/out_last       : packed word, real byte count, end of packet
// Short final words are padded with PAD_BYTE in the unfilled lanes.
module byte_stream_packer
  import stream_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES,
  parameter bit          SWAP_BYTES = 1'b0,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [7:0]                        in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [8*WORD_BYTES-1:0]           out_data,
  output logic [$clog2(WORD_BYTES+1)-1:0]   out_bytes,
  output logic                              out_last
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES + 1);
  localparam int unsigned PW    = 8*WORD_BYTES + CNT_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t                    cnt_q, cnt_d;
  byte_t                   acc_q [WORD_BYTES];
  byte_t                   acc_d [WORD_BYTES];
  logic                    ready_q, ready_d;
  int unsigned             cnt_int;
  logic                    accept, complete, pop, full, empty;
  logic [1:0]              occ, occ_nx;
  logic [8*WORD_BYTES-1:0] word;
  logic [PW-1:0]           din, dout;

  assign cnt_int  = 32'(cnt_q);
  assign in_ready = ready_q;
  assign accept   = in_valid && ready_q;
  assign complete = accept && ((cnt_q == cnt_t'(WORD_BYTES - 1)) || in_last);
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;

  // Completed word: earlier bytes from the accumulator, the current byte
  // straight from the input, remaining lanes padded.
  always_comb begin
    word = '0;
    for (int unsigned l = 0; l < WORD_BYTES; l++) begin
      if (lane_idx(l, WORD_BYTES, SWAP_BYTES) < cnt_int)
        word[8*l +: 8] = acc_q[l];
      else if (lane_idx(l, WORD_BYTES, SWAP_BYTES) == cnt_int)
        word[8*l +: 8] = in_data;
      else
        word[8*l +: 8] = PAD_BYTE;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      for (int unsigned l = 0; l < WORD_BYTES; l++) begin
        if (lane_idx(cnt_int, WORD_BYTES, SWAP_BYTES) == l) acc_d[l] = in_data;
      end
      cnt_d = complete ? '0 : cnt_t'(cnt_q + 1'b1);
    end
  end

  // in_ready is a register holding "buffer will not be full next cycle",
  // so it never depends combinationally on out_ready or in_valid.
  always_comb begin
    occ     = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    occ_nx  = occ + 2'(complete) - 2'(pop);
    ready_d = (occ_nx != 2'd2);
  end

  assign din = {word, cnt_t'(cnt_q + 1'b1), in_last};

  packer_fifo2 #(.W(PW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (complete),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .din   (din),
    .dout  (dout)
  );

  assign out_data  = dout[PW-1 -: 8*WORD_BYTES];
  assign out_bytes = dout[1 +: CNT_W];
  assign out_last  = dout[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int unsigned l = 0; l < WORD_BYTES; l++) acc_q[l] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      acc_q   <= acc_d;
    end
  end

  a_in_stable: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> ($stable(in_data) && $stable(in_last)));

endmodule

// File: tb/tb_byte_stream_packer.sv
module tb_byte_stream_packer;

  localparam int unsigned WB = 4;

  typedef struct packed {
    logic [31:0] d0;   // SWAP=0, PAD=00
    logic [31:0] d1;   // SWAP=1, PAD=00
    logic [31:0] d2;   // SWAP=0, PAD=ff
    logic [2:0]  nb;
    logic        lst;
  } wrd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, ol0, ol1, ol2;
  logic [31:0] od0, od1, od2;
  logic [2:0]  ob0, ob1, ob2;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  mdl_q[$];
  wrd_t        exp_q[$];
  wrd_t        act_q[$];

  always #5 clk = ~clk;

  byte_stream_packer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_bytes(ob0), .out_last(ol0));

  byte_stream_packer #(.SWAP_BYTES(1'b1)) u_swap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_bytes(ob1), .out_last(ol1));

  byte_stream_packer #(.PAD_BYTE(8'hff)) u_pad (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_bytes(ob2), .out_last(ol2));

  // Reference: gather the packet's bytes in arrival order and lay them out per variant.
  function automatic void model_accept(input logic [7:0] d, input logic l);
    wrd_t w;
    int unsigned n;
    mdl_q.push_back(d);
    if (mdl_q.size() == WB || l) begin
      n = mdl_q.size();
      w = '0;
      for (int unsigned p = 0; p < WB; p++) begin
        w.d0[8*(WB-1-p) +: 8] = (p < n) ? mdl_q[p] : 8'h00;
        w.d1[8*p +: 8]        = (p < n) ? mdl_q[p] : 8'h00;
        w.d2[8*(WB-1-p) +: 8] = (p < n) ? mdl_q[p] : 8'hff;
      end
      w.nb  = 3'(n);
      w.lst = l;
      exp_q.push_back(w);
      mdl_q.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && ov0 && out_ready)
      act_q.push_back({od0, od1, od2, ob0, ol0});
  end

  // Present one byte from posedge+1 until accepted; returns at posedge+1 after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic l, input bit rnd);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int c = 0; c < 200; c++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      if (acc) begin
        model_accept(d, l);
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: byte %h not accepted within 200 cycles, expected acceptance", d);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #11;
    n_cmp++; if ({rdy0, rdy1, rdy2} !== 3'b000) begin n_err++; $display("FAIL rst_in_ready: got %b required 000", {rdy0, rdy1, rdy2}); end
    n_cmp++; if ({ov0, ol0, ob0} !== 5'b0) begin n_err++; $display("FAIL rst_ctrl: got v=%b l=%b b=%0d required 0", ov0, ol0, ob0); end
    n_cmp++; if (od0 !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h required 0", od0); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({rdy0, rdy1, rdy2} !== 3'b111) begin n_err++; $display("FAIL rel_in_ready: got %b required 111", {rdy0, rdy1, rdy2}); end
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rel_out_valid: got %b required 0", ov0); end
  endtask

  task automatic test_lane_order;
    out_ready = 1'b1;
    send_byte(8'hde, 1'b0, 1'b0);
    send_byte(8'had, 1'b0, 1'b0);
    send_byte(8'hbe, 1'b0, 1'b0);
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL early_word: out_valid got %b required 0", ov0); end
    send_byte(8'hef, 1'b1, 1'b0);
    n_cmp++; if (ov0 !== 1'b1) begin n_err++; $display("FAIL latency: out_valid got %b required 1", ov0); end
    n_cmp++; if (od0 !== 32'hdeadbeef) begin n_err++; $display("FAIL swap0_data: got %h required deadbeef", od0); end
    n_cmp++; if (od1 !== 32'hefbeadde) begin n_err++; $display("FAIL swap1_data: got %h required efbeadde", od1); end
    n_cmp++; if ({ob0, ol0} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL full_meta: got bytes=%0d last=%b required 4/1", ob0, ol0); end
    @(posedge clk); #1;
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL no_extra_word: out_valid got %b required 0", ov0); end
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    n_cmp++; if (od0 !== 32'h11220000) begin n_err++; $display("FAIL short_pad00: got %h required 11220000", od0); end
    n_cmp++; if (od2 !== 32'h1122ffff) begin n_err++; $display("FAIL short_padff: got %h required 1122ffff", od2); end
    n_cmp++; if (od1 !== 32'h00002211) begin n_err++; $display("FAIL short_swap: got %h required 00002211", od1); end
    n_cmp++; if ({ob0, ol0} !== {3'd2, 1'b1}) begin n_err++; $display("FAIL short_meta: got bytes=%0d last=%b required 2/1", ob0, ol0); end
    send_byte(8'h5a, 1'b1, 1'b0);
    n_cmp++; if ({od0, ob0, ol0} !== {32'h5a000000, 3'd1, 1'b1}) begin n_err++; $display("FAIL single_byte: got %h/%0d/%b required 5a000000/1/1", od0, ob0, ol0); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    logic [7:0] k;
    bit         a;
    exp_q.delete(); act_q.delete(); mdl_q.delete();
    mon_en = 1'b1;
    out_ready = 1'b0;
    k = 8'h00;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_data = k; in_last = 1'b0;
      @(negedge clk); a = rdy0;
      @(posedge clk); #1;
      if (a) begin model_accept(k, 1'b0); k = k + 8'h01; end
    end
    n_cmp++; if (k !== 8'd8) begin n_err++; $display("FAIL bp_accepted: got %0d bytes required 8", k); end
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", rdy0); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({ov0, od0} !== {1'b1, 32'h00010203}) begin n_err++; $display("FAIL bp_hold: got v=%b %h required 1 00010203", ov0, od0); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int unsigned i = 8; i < 12; i++) send_byte(8'(i), (i == 11), 1'b0);
    repeat (8) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++; if (act_q.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d words required 3", act_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_word%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midword;
    out_ready = 1'b1;
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ov0, ob0, ol0, rdy0} !== 6'b0) begin n_err++; $display("FAIL mid_rst_ctrl: got v=%b b=%0d l=%b rdy=%b required 0", ov0, ob0, ol0, rdy0); end
    n_cmp++; if (od0 !== 32'h0) begin n_err++; $display("FAIL mid_rst_data: got %h required 0", od0); end
    #3 rst = 1'b0;
    mdl_q.delete();
    @(posedge clk); #1;
    n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %b required 1", rdy0); end
    send_byte(8'haa, 1'b0, 1'b0);
    send_byte(8'hbb, 1'b0, 1'b0);
    send_byte(8'hcc, 1'b0, 1'b0);
    send_byte(8'hdd, 1'b0, 1'b0);
    n_cmp++; if ({ov0, od0, ob0, ol0} !== {1'b1, 32'haabbccdd, 3'd4, 1'b0}) begin n_err++; $display("FAIL mid_next_word: got v=%b %h/%0d/%b required 1 aabbccdd/4/0", ov0, od0, ob0, ol0); end
    n_cmp++; if (od1 !== 32'hddccbbaa) begin n_err++; $display("FAIL mid_next_swap: got %h required ddccbbaa", od1); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_streaming;
    exp_q.delete(); act_q.delete(); mdl_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      send_byte(8'($urandom), (i == 39) || ($urandom_range(0, 3) == 0), 1'b1);
    end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL st_count: got %0d words required %0d", act_q.size(), exp_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL st_word%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL st_drained: out_valid got %b required 0", ov0); end
  endtask

  initial begin
    test_reset;
    test_lane_order;
    test_backpressure;
    test_reset_midword;
    test_streaming;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
